bram_port_arbiter: RTL

Two-requester arbiter that shares one port of the team's byte-write true-dual-port BRAM (read-first, one-cycle registered read) between two masters. Typical placement: the CPU data-memory port (M0) and the debug/program loader (M1) both reach data RAM port B. The block grants at most one access per cycle and drives the RAM port directly. It returns read data with a valid strobe one cycle after the grant and bounds how long one master can hold the port while the other waits.

---
 rtl/bram_port_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/bram_port_arbiter.sv
// Two-master arbiter sharing one port of a read-first, one-cycle-latency BRAM.
// Grants are combinational; a master keeps the port for at most MAX_BURST cycles under contention.
module bram_port_arbiter #(
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic [NUM_COL-1:0]    m0_wen,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic [NUM_COL-1:0]    m1_wen,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  ram_en,
  output logic [NUM_COL-1:0]    ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  logic             last;
  logic             active;
  logic [CNT_W-1:0] cnt;
  logic             any_gnt;
  logic             sel;
  logic             vld0_p1;
  logic             vld1_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
  endfunction

  // Stage p0: grant decision and RAM drive, same cycle as the request
  always_comb begin
    any_gnt = 1'b0;
    sel     = 1'b0;
    if (!rst) begin
      if (m0_req && m1_req) begin
        any_gnt = 1'b1;
        sel     = (active && (cnt < CNT_MAX)) ? last : ~last;
      end else if (m0_req) begin
        any_gnt = 1'b1;
        sel     = 1'b0;
      end else if (m1_req) begin
        any_gnt = 1'b1;
        sel     = 1'b1;
      end
    end
  end

  assign m0_gnt   = any_gnt && !sel;
  assign m1_gnt   = any_gnt && sel;
  assign ram_en   = any_gnt;
  assign ram_wen  = !any_gnt ? '0 : (sel ? m1_wen : m0_wen);
  assign ram_addr = sel ? m1_addr : m0_addr;
  assign ram_din  = sel ? m1_wdata : m0_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      last    <= 1'b1;
      active  <= 1'b0;
      cnt     <= '0;
      vld0_p1 <= 1'b0;
      vld1_p1 <= 1'b0;
    end else begin
      if (any_gnt) begin
        cnt    <= ((sel == last) && active) ? sat_inc(cnt) : CNT_W'(1);
        last   <= sel;
        active <= 1'b1;
      end else begin
        cnt    <= '0;
        active <= 1'b0;
      end
      vld0_p1 <= m0_gnt && (m0_wen == '0);
      vld1_p1 <= m1_gnt && (m1_wen == '0);
    end
  end

  // Stage p1: registered RAM output returned to both masters
  assign m0_rvalid = vld0_p1;
  assign m1_rvalid = vld1_p1;
  assign m0_rdata  = ram_dout;
  assign m1_rdata  = ram_dout;

endmodule
